// File: rtl/organ_key_conditioner_if.sv
// Organ key conditioner pin bundle: raw bouncing buttons in,
// clean active-low note/octave lines and key-event pulse out.
interface organ_key_conditioner_if;
    logic [1:4] button_n;
    logic       octaveUp_n;
    logic       octaveDown_n;
    logic [1:4] noteButton_n;
    logic [1:0] octaveSelect_n;
    logic       keyEvent;

    modport master (
        output button_n,
        output octaveUp_n,
        output octaveDown_n,
        input  noteButton_n,
        input  octaveSelect_n,
        input  keyEvent
    );

    modport slave (
        input  button_n,
        input  octaveUp_n,
        input  octaveDown_n,
        output noteButton_n,
        output octaveSelect_n,
        output keyEvent
    );
endinterface

// File: rtl/organ_key_conditioner.sv
// Organ key conditioner: synchronise and debounce four note buttons
// plus octave up/down buttons, and keep a 2-bit octave register.
//
// Ports:
//   oneMHzClock        system clock, rising edge
//   reset_n            asynchronous active-low reset
//   kif.button_n       raw note buttons [1:4], active-low, bouncing
//   kif.octaveUp_n     raw octave-up button, active-low
//   kif.octaveDown_n   raw octave-down button, active-low
//   kif.noteButton_n   debounced note buttons, active-low
//   kif.octaveSelect_n inverted octave register
//   kif.keyEvent       one-cycle pulse on any debounced note press
//
// Build option: define OCTAVE_WRAP_EN to make octave stepping wrap
// modulo 4 instead of saturating at 0 and 3.
module organ_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int DEFAULT_OCTAVE  = 2
) (
    input logic                      oneMHzClock,
    input logic                      reset_n,
    organ_key_conditioner_if.slave   kif
);

    localparam int NCH = 6;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [1:0]    OCT_RST = 2'(DEFAULT_OCTAVE);

    // Channel map: 0..3 = notes 1..4, 4 = octave up, 5 = octave down.
    localparam int CH_UP = 4;
    localparam int CH_DN = 5;

    logic [NCH-1:0] raw;

    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync1_d;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] sync2_d;

    logic [NCH-1:0] stable_q;
    logic [NCH-1:0] stable_d;

    logic [NCH-1:0][CW-1:0] cnt_q;
    logic [NCH-1:0][CW-1:0] cnt_d;

    logic [NCH-1:0] press;

    logic key_event_q;
    logic key_event_d;
    logic up_press_q;
    logic up_press_d;
    logic dn_press_q;
    logic dn_press_d;

    logic [1:0] octave_q;
    logic [1:0] octave_d;
    logic [1:0] oct_up;
    logic [1:0] oct_dn;

    assign raw = {
        kif.octaveDown_n,
        kif.octaveUp_n,
        kif.button_n[4],
        kif.button_n[3],
        kif.button_n[2],
        kif.button_n[1]
    };

    // Two-flop synchroniser for every raw input.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Debounce: the counter only runs while the synced level
    // disagrees with the stable state. Reaching CNT_MAX with the
    // level still different accepts the new level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = ~stable_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Press = stable state going released(1) -> pressed(0).
    assign press = stable_q & ~stable_d;

    // keyEvent is registered alongside the stable flops so the
    // pulse lines up with the noteButton_n falling edge.
    always_comb begin
        key_event_d = |press[3:0];
        up_press_d  = press[CH_UP];
        dn_press_d  = press[CH_DN];
    end

`ifdef OCTAVE_WRAP_EN
    always_comb begin
        oct_up = octave_q + 2'd1;
        oct_dn = octave_q - 2'd1;
    end
`else
    always_comb begin
        oct_up = (octave_q == 2'd3) ? 2'd3 : octave_q + 2'd1;
        oct_dn = (octave_q == 2'd0) ? 2'd0 : octave_q - 2'd1;
    end
`endif

    // Simultaneous up and down presses cancel out.
    always_comb begin
        octave_d = octave_q;
        unique case ({up_press_q, dn_press_q})
            2'b10:   octave_d = oct_up;
            2'b01:   octave_d = oct_dn;
            default: octave_d = octave_q;
        endcase
    end

    always_ff @(posedge oneMHzClock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            stable_q    <= '1;
            cnt_q       <= '0;
            key_event_q <= 1'b0;
            up_press_q  <= 1'b0;
            dn_press_q  <= 1'b0;
            octave_q    <= OCT_RST;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            key_event_q <= key_event_d;
            up_press_q  <= up_press_d;
            dn_press_q  <= dn_press_d;
            octave_q    <= octave_d;
        end
    end

    assign kif.noteButton_n = {
        stable_q[0],
        stable_q[1],
        stable_q[2],
        stable_q[3]
    };
    assign kif.octaveSelect_n = ~octave_q;
    assign kif.keyEvent       = key_event_q;

endmodule

// File: tb/tb_organ_key_conditioner.sv
// Scoreboard bench for organ_key_conditioner: stimulus pushes the
// expected output-change events, a monitor pops them on each change.
module tb_organ_key_conditioner;

    localparam int D   = 4;
    localparam int DEF = 2;

    typedef struct {
        int         cyc;
        logic [6:0] tup;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   failures;

    exp_t       q[$];
    logic [6:0] last_tup;
    bit         have_last;
    logic [6:0] prev_tup;

    logic [1:4] cur_nb;
    logic [1:0] cur_oct;

    organ_key_conditioner_if kif();

    organ_key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .DEFAULT_OCTAVE (DEF)
    ) dut (
        .oneMHzClock(clk),
        .reset_n    (reset_n),
        .kif        (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] step(logic [1:0] o, bit up);
`ifdef OCTAVE_WRAP_EN
        return up ? o + 2'd1 : o - 2'd1;
`else
        if (up) return (o == 2'd3) ? 2'd3 : o + 2'd1;
        return (o == 2'd0) ? 2'd0 : o - 2'd1;
`endif
    endfunction

    task automatic expect_ev(int c, logic [1:4] nb,
                             logic [1:0] os, logic ke);
        exp_t e;
        e.cyc = c;
        e.tup = {nb, os, ke};
        if (!have_last || e.tup != last_tup) begin
            q.push_back(e);
            last_tup  = e.tup;
            have_last = 1'b1;
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitor: every change of the output tuple is one DUT event.
    always @(negedge clk) begin
        logic [6:0] t;
        exp_t e;
        t = {kif.noteButton_n, kif.octaveSelect_n, kif.keyEvent};
        if (t !== prev_tup) begin
            prev_tup = t;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got=%b", cyc, t);
            end else begin
                e = q.pop_front();
                if (t !== e.tup) begin
                    failures++;
                    $display("FAIL event_value cyc=%0d got=%b exp=%b",
                             cyc, t, e.tup);
                end
                if (e.cyc >= 0) begin
                    checks++;
                    if (cyc != e.cyc) begin
                        failures++;
                        $display("FAIL event_time got=%0d exp=%0d tup=%b",
                                 cyc, e.cyc, e.tup);
                    end
                end
            end
        end
    end

    task automatic notes(logic [1:4] nb);
        int c;
        logic [1:4] fell;
        c = cyc;
        fell = cur_nb & ~nb;
        kif.button_n = nb;
        cur_nb = nb;
        if (fell != 4'b0000) begin
            expect_ev(c + D + 2, nb, ~cur_oct, 1'b1);
            expect_ev(c + D + 3, nb, ~cur_oct, 1'b0);
        end else begin
            expect_ev(c + D + 2, nb, ~cur_oct, 1'b0);
        end
        tick(12);
    endtask

    task automatic oct_press(bit up, bit dn, int hold);
        int c;
        c = cyc;
        kif.octaveUp_n   = ~up;
        kif.octaveDown_n = ~dn;
        if (up && !dn) cur_oct = step(cur_oct, 1'b1);
        if (dn && !up) cur_oct = step(cur_oct, 1'b0);
        expect_ev(c + D + 3, cur_nb, ~cur_oct, 1'b0);
        tick(hold);
        kif.octaveUp_n   = 1'b1;
        kif.octaveDown_n = 1'b1;
        tick(12);
    endtask

    task automatic do_reset();
        logic [1:4] nb_exp;
        logic [1:0] os_exp;
        reset_n = 1'b0;
        cur_oct = 2'(DEF);
        expect_ev(-1, 4'b1111, ~cur_oct, 1'b0);
        #1;
        nb_exp = 4'b1111;
        os_exp = ~cur_oct;
        checks++;
        if (kif.noteButton_n !== nb_exp ||
            kif.octaveSelect_n !== os_exp ||
            kif.keyEvent !== 1'b0) begin
            failures++;
            $display("FAIL reset_immediate got=%b/%b/%b exp=%b/%b/0",
                     kif.noteButton_n, kif.octaveSelect_n,
                     kif.keyEvent, nb_exp, os_exp);
        end
        tick(3);
        reset_n = 1'b1;
    endtask

    initial begin
        int c;
        checks    = 0;
        failures  = 0;
        have_last = 1'b0;
        cur_nb    = 4'b1111;
        cur_oct   = 2'(DEF);

        kif.button_n     = 4'b1111;
        kif.octaveUp_n   = 1'b1;
        kif.octaveDown_n = 1'b1;
        reset_n          = 1'b0;
        expect_ev(-1, 4'b1111, ~cur_oct, 1'b0);
        tick(3);
        reset_n = 1'b1;
        tick(5);

        // Clean press and release of note 1.
        notes(4'b0111);
        notes(4'b1111);

        // Bouncing note 2: never held long enough.
        kif.button_n[2] = 1'b0;
        tick(3);
        kif.button_n[2] = 1'b1;
        tick(1);
        kif.button_n[2] = 1'b0;
        tick(3);
        kif.button_n[2] = 1'b1;
        tick(12);

        // Five octave-up presses from the default.
        for (int i = 0; i < 5; i++) oct_press(1'b1, 1'b0, 10);

        // One down, then up+down together held 20 cycles.
        oct_press(1'b0, 1'b1, 10);
        oct_press(1'b1, 1'b1, 20);

        // Down presses past the bottom.
        for (int i = 0; i < 3; i++) oct_press(1'b0, 1'b1, 10);

        // Two notes pressing on the same edge: a single pulse.
        notes(4'b1100);
        notes(4'b1111);

        // Reset mid-press with octave at 3 and note 4 held.
        tick(1);
        do_reset();
        tick(12);
        oct_press(1'b1, 1'b0, 10);
        notes(4'b1110);
        tick(1);
        do_reset();
        c = cyc;
        expect_ev(c + D + 2, 4'b1110, ~cur_oct, 1'b1);
        expect_ev(c + D + 3, 4'b1110, ~cur_oct, 1'b0);
        tick(12);
        notes(4'b1111);

        tick(20);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event exp_cyc=%0d exp=%b got=none",
                     e.cyc, e.tup);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/organ_key_conditioner.md
Name: organ_key_conditioner

Overview:
- Front-end stage directly upstream of the digital organ tone generator.
- Synchronises and debounces the four raw note buttons and two octave up/down buttons.
- Keeps a 2-bit octave register that the buttons step up and down.
- Drives clean, active-low note and octave-select signals that connect straight onto the organ's button_n and octaveSelect_n inputs.

Parameters:
- DEBOUNCE_CYCLES, 10000, consecutive clock cycles an input must hold a new level before it is accepted (10 ms at 1 MHz); legal range 1..65535.
- DEFAULT_OCTAVE, 2, octave register value after reset; legal range 0..3.

Ports:
- oneMHzClock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- button_n  input  [1:4]  raw note buttons, active-low, asynchronous to the clock, bouncing
- octaveUp_n  input  1  raw octave-up button, active-low, bouncing
- octaveDown_n  input  1  raw octave-down button, active-low, bouncing
- noteButton_n  output  [1:4]  debounced note buttons, active-low
- octaveSelect_n  output  [1:0]  inverted octave register (3 = highest octave)
- keyEvent  output  1  one-cycle pulse when any debounced note goes from released to pressed

Behaviour:
- Interface: one clock, oneMHzClock. Reset reset_n is asynchronous and active-low, and is the only reset.
- Reset values:
  - noteButton_n = 4'b1111
  - octaveSelect_n = ~DEFAULT_OCTAVE[1:0]
  - keyEvent = 0
  - all synchroniser flops = 1 (released)
  - all debounce counters = 0
- Synchroniser: each of the six raw inputs passes through a 2-flop synchroniser before any other logic uses it.
- Debounce: six identical channels, each with a stable-state flop and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synced level equals stable state: counter clears to 0.
  - Synced level differs from stable state: counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the level still differs: stable state toggles and the counter clears on that same edge.
  - Any single-cycle return to the stable level clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
  - Latency from a clean raw edge to the output change is exactly 2 + DEBOUNCE_CYCLES rising edges.
- noteButton_n: registered directly from the four note stable-state flops. More than one note may be active at once; there is no priority or locking.
- keyEvent: high for exactly one cycle on the edge where any note stable state goes 1->0. Several notes pressing on the same edge still give a single pulse.
- Octave register, 2 bits, updated only on debounced press edges (stable 1->0) of the up/down channels. Holding a button gives exactly one step, with no auto-repeat.
  - Up press alone: octave+1, saturating at 3.
  - Down press alone: octave-1, saturating at 0.
  - Up and down press edges on the same cycle: no change.
  - Release edges: no effect.
- octaveSelect_n = ~octave, registered, and updated one cycle after the press edge.
- Reset mid-operation:
  - Counters and stable states return to released.
  - The octave returns to DEFAULT_OCTAVE.
  - A button still held after reset deasserts is treated as a fresh press: it debounces again, steps the octave, and pulses keyEvent.

Optional Feature:
- Macro OCTAVE_WRAP_EN.
- Defined: octave stepping wraps modulo 4 (up from 3 goes to 0, down from 0 goes to 3).
- Undefined (default): stepping saturates as described under Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset and release: DEBOUNCE_CYCLES=4, DEFAULT_OCTAVE=2, pulse reset_n low with all inputs high -> noteButton_n=4'b1111, octaveSelect_n=2'b01, keyEvent=0.
- Clean press: button_n[1] held low from cycle 0 -> noteButton_n[1] falls at rising edge 6 (2+4), and keyEvent is high for exactly that one cycle.
- Bounce rejection: button_n[2] low 3 cycles, high 1, low 3, high -> noteButton_n stays 4'b1111 and keyEvent never asserts.
- Octave saturation: five debounced octaveUp_n presses from reset -> octaveSelect_n goes 2'b01, 2'b00, then stays 2'b00. With OCTAVE_WRAP_EN the sequence is 01, 00, 11, 10, 01, 00.
- Simultaneous up and down: both released to pressed on the same cycle -> octaveSelect_n unchanged. A hold of 20 cycles produces no further step.
- Reset mid-press: octave at 3 and button_n[4] held, assert reset_n -> noteButton_n=4'b1111 and octaveSelect_n=2'b01 immediately. After release of reset, noteButton_n[4] falls 6 edges later with one keyEvent pulse.
